// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter (logical / arithmetic).
// Resolves one bit of the shift amount per clock, LSB first, so the
// latency is always SHAMT_W cycles whatever the amount.
// Optional feature macro: SHIFT_RIGHT_ROTATE_EN adds a rotate-right
// mode selected by input rot (rot has priority over arith).
//
// Handshake: start is sampled only while busy=0; the operands are latched
// on that edge. done pulses for one cycle when res is updated, and busy is
// low in that same cycle, so a start held high then is taken immediately.
module shift_right_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  input  logic               arith,
`ifdef SHIFT_RIGHT_ROTATE_EN
  input  logic               rot,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

  state_t               state;
  logic [WIDTH-1:0]     work;
  logic [SHAMT_W-1:0]   amt;
  logic                 fill;
  logic [SHAMT_W-1:0]   stage;
`ifdef SHIFT_RIGHT_ROTATE_EN
  logic                 rot_q;
`endif

  // Per-stage candidate result: stage k moves work right by 2^k.
  logic [WIDTH-1:0] cand [SHAMT_W];
  logic [WIDTH-1:0] step;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
`ifdef SHIFT_RIGHT_ROTATE_EN
    // Rotate feeds the bits falling off the bottom back into the top.
    always_comb begin
      if (rot_q) cand[k] = {work[SH-1:0], work[WIDTH-1:SH]};
      else       cand[k] = {{SH{fill}}, work[WIDTH-1:SH]};
    end
`else
    // Shift fills the vacated top bits with the latched fill bit.
    always_comb cand[k] = {{SH{fill}}, work[WIDTH-1:SH]};
`endif
  end

  // Apply the current stage only if its bit of the shift amount is set.
  always_comb begin
    step = work;
    if (amt[stage]) step = cand[stage];
  end

  // Control FSM with registered busy/done/res outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      work  <= '0;
      amt   <= '0;
      fill  <= 1'b0;
      stage <= '0;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= A;
            amt   <= B;
            fill  <= arith & A[WIDTH-1];
            stage <= '0;
`ifdef SHIFT_RIGHT_ROTATE_EN
            rot_q <= rot;
`endif
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= step;
          stage <= stage + 1'b1;
          if (stage == LAST_STAGE) begin
            res   <= step;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
